// File: rtl/ifu_idu_exe.sv
// Single-cycle RV64I fetch/decode/execute slice.
// Decode and execute are purely combinational. The only state is the sticky halt flag.
module ifu_idu_exe (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] pc_i,
  output logic [63:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  input  logic [63:0] src1_i,
  input  logic [63:0] src2_i,
  output logic [4:0]  rd_o,
  output logic        wen_o,
  output logic [63:0] res_o,
  output logic [63:0] npc_o,
  output logic [3:0]  mem_op_o,
  output logic        mem_valid_o,
  output logic        illegal_o,
  output logic        halt_o
);

  typedef enum logic [6:0] {
    OPC_LOAD      = 7'b0000011,
    OPC_OP_IMM    = 7'b0010011,
    OPC_AUIPC     = 7'b0010111,
    OPC_OP_IMM_32 = 7'b0011011,
    OPC_STORE     = 7'b0100011,
    OPC_OP        = 7'b0110011,
    OPC_LUI       = 7'b0110111,
    OPC_OP_32     = 7'b0111011,
    OPC_BRANCH    = 7'b1100011,
    OPC_JALR      = 7'b1100111,
    OPC_JAL       = 7'b1101111,
    OPC_SYSTEM    = 7'b1110011
  } opcode_e;

  localparam logic [31:0] INST_NOP    = 32'h0000_0013;
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [6:0]  F7_ZERO     = 7'b0000000;
  localparam logic [6:0]  F7_ALT      = 7'b0100000;
  localparam logic [5:0]  F6_ZERO     = 6'b000000;
  localparam logic [5:0]  F6_ALT      = 6'b010000;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  logic [31:0] inst;
  opcode_e     opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [5:0]  f6;
  logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [63:0] pc_plus4;
  logic [5:0]  shamt_imm;
  logic [5:0]  shamt_reg;
  logic        wen_raw;
  logic        ill;
  logic        taken;
  logic        mem_valid;
  logic [63:0] res;
  logic [63:0] npc;
  logic        halt_q;

  // Fetch: reset substitutes a NOP so nothing architectural happens while held.
  always_comb begin
    inst = rst_i ? INST_NOP : imem_rdata_i;
  end

  assign imem_addr_o = pc_i;
  assign inst_o      = inst;
  assign opc         = opcode_e'(inst[6:0]);
  assign f3          = inst[14:12];
  assign f7          = inst[31:25];
  assign f6          = inst[31:26];
  assign rs1_o       = inst[19:15];
  assign rs2_o       = inst[24:20];
  assign rd_o        = inst[11:7];
  assign shamt_imm   = inst[25:20];
  assign shamt_reg   = src2_i[5:0];
  assign pc_plus4    = pc_i + 64'd4;

  assign imm_i = {{52{inst[31]}}, inst[31:20]};
  assign imm_s = {{52{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {{32{inst[31]}}, inst[31:12], 12'b0};
  assign imm_j = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Branch condition evaluation.
  always_comb begin
    taken = 1'b0;
    case (f3)
      3'd0:    taken = (src1_i == src2_i);
      3'd1:    taken = (src1_i != src2_i);
      3'd4:    taken = ($signed(src1_i) <  $signed(src2_i));
      3'd5:    taken = ($signed(src1_i) >= $signed(src2_i));
      3'd6:    taken = (src1_i <  src2_i);
      3'd7:    taken = (src1_i >= src2_i);
      default: taken = 1'b0;
    endcase
  end

  // Execute: result, next PC, write enable and legality per instruction class.
  always_comb begin
    res       = '0;
    npc       = pc_plus4;
    wen_raw   = 1'b0;
    ill       = 1'b0;
    mem_valid = 1'b0;
    case (opc)
      OPC_LUI: begin
        res     = imm_u;
        wen_raw = 1'b1;
      end
      OPC_AUIPC: begin
        res     = pc_i + imm_u;
        wen_raw = 1'b1;
      end
      OPC_JAL: begin
        res     = pc_plus4;
        npc     = pc_i + imm_j;
        wen_raw = 1'b1;
      end
      OPC_JALR: begin
        res     = pc_plus4;
        npc     = (src1_i + imm_i) & ~64'd1;
        wen_raw = 1'b1;
        ill     = (f3 != 3'd0);
      end
      OPC_BRANCH: begin
        ill = (f3 == 3'd2) || (f3 == 3'd3);
        if (taken) npc = pc_i + imm_b;
      end
      OPC_LOAD: begin
        res       = src1_i + imm_i;
        mem_valid = 1'b1;
        wen_raw   = 1'b1;
        ill       = (f3 == 3'd7);
      end
      OPC_STORE: begin
        res       = src1_i + imm_s;
        mem_valid = 1'b1;
        ill       = f3[2];
      end
      OPC_OP_IMM: begin
        wen_raw = 1'b1;
        case (f3)
          3'd0: res = src1_i + imm_i;
          3'd2: res = {63'b0, $signed(src1_i) < $signed(imm_i)};
          3'd3: res = {63'b0, src1_i < imm_i};
          3'd4: res = src1_i ^ imm_i;
          3'd6: res = src1_i | imm_i;
          3'd7: res = src1_i & imm_i;
          3'd1: begin
            res = src1_i << shamt_imm;
            ill = (f6 != F6_ZERO);
          end
          default: begin
            if (f6 == F6_ZERO)     res = src1_i >> shamt_imm;
            else if (f6 == F6_ALT) res = $signed(src1_i) >>> shamt_imm;
            else                   ill = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        wen_raw = 1'b1;
        // Only ADD/SUB and SRL/SRA accept the alternate funct7.
        if (f7 == F7_ALT) begin
          if (f3 == 3'd0)      res = src1_i - src2_i;
          else if (f3 == 3'd5) res = $signed(src1_i) >>> shamt_reg;
          else                 ill = 1'b1;
        end else if (f7 == F7_ZERO) begin
          case (f3)
            3'd0:    res = src1_i + src2_i;
            3'd1:    res = src1_i << shamt_reg;
            3'd2:    res = {63'b0, $signed(src1_i) < $signed(src2_i)};
            3'd3:    res = {63'b0, src1_i < src2_i};
            3'd4:    res = src1_i ^ src2_i;
            3'd5:    res = src1_i >> shamt_reg;
            3'd6:    res = src1_i | src2_i;
            default: res = src1_i & src2_i;
          endcase
        end else begin
          ill = 1'b1;
        end
      end
      OPC_OP_IMM_32: begin
        wen_raw = 1'b1;
        // f7 covers imm[5], so a 6-bit word shift amount is rejected here.
        case (f3)
          3'd0: res = sext32(src1_i[31:0] + imm_i[31:0]);
          3'd1: begin
            if (f7 == F7_ZERO) res = sext32(src1_i[31:0] << inst[24:20]);
            else               ill = 1'b1;
          end
          3'd5: begin
            if (f7 == F7_ZERO)     res = sext32(src1_i[31:0] >> inst[24:20]);
            else if (f7 == F7_ALT) res = sext32($signed(src1_i[31:0]) >>> inst[24:20]);
            else                   ill = 1'b1;
          end
          default: ill = 1'b1;
        endcase
      end
      OPC_OP_32: begin
        wen_raw = 1'b1;
        case (f3)
          3'd0: begin
            if (f7 == F7_ZERO)     res = sext32(src1_i[31:0] + src2_i[31:0]);
            else if (f7 == F7_ALT) res = sext32(src1_i[31:0] - src2_i[31:0]);
            else                   ill = 1'b1;
          end
          3'd1: begin
            if (f7 == F7_ZERO) res = sext32(src1_i[31:0] << shamt_reg[4:0]);
            else               ill = 1'b1;
          end
          3'd5: begin
            if (f7 == F7_ZERO)     res = sext32(src1_i[31:0] >> shamt_reg[4:0]);
            else if (f7 == F7_ALT) res = sext32($signed(src1_i[31:0]) >>> shamt_reg[4:0]);
            else                   ill = 1'b1;
          end
          default: ill = 1'b1;
        endcase
      end
      OPC_SYSTEM: begin
        ill = (inst != INST_ECALL) && (inst != INST_EBREAK);
      end
      default: ill = 1'b1;
    endcase
    // Illegal instructions fall through as a plain PC+4 with no side effects.
    if (ill) begin
      res       = '0;
      npc       = pc_plus4;
      wen_raw   = 1'b0;
      mem_valid = 1'b0;
    end
  end

  assign res_o       = res;
  assign npc_o       = npc;
  assign wen_o       = wen_raw && (rd_o != 5'd0) && !ill;
  assign illegal_o   = ill;
  assign mem_valid_o = mem_valid;
  assign mem_op_o    = {opc == OPC_STORE, f3};

  // Sticky halt: set by an executed EBREAK, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i)                    halt_q <= 1'b0;
    else if (inst == INST_EBREAK) halt_q <= 1'b1;
  end

  assign halt_o = halt_q;

endmodule

// File: tb/tb_ifu_idu_exe.sv
// Directed, table-driven bench for ifu_idu_exe plus hand-written halt/reset sequences.
module tb_ifu_idu_exe;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [63:0] pc_i;
  logic [63:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic [31:0] inst_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [63:0] src1_i, src2_i;
  logic        wen_o;
  logic [63:0] res_o, npc_o;
  logic [3:0]  mem_op_o;
  logic        mem_valid_o, illegal_o, halt_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ifu_idu_exe dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .pc_i        (pc_i),
    .imem_addr_o (imem_addr_o),
    .imem_rdata_i(imem_rdata_i),
    .inst_o      (inst_o),
    .rs1_o       (rs1_o),
    .rs2_o       (rs2_o),
    .src1_i      (src1_i),
    .src2_i      (src2_i),
    .rd_o        (rd_o),
    .wen_o       (wen_o),
    .res_o       (res_o),
    .npc_o       (npc_o),
    .mem_op_o    (mem_op_o),
    .mem_valid_o (mem_valid_o),
    .illegal_o   (illegal_o),
    .halt_o      (halt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] s1;
    logic [63:0] s2;
    logic        chk_res;
    logic [63:0] res;
    logic [63:0] npc;
    logic        wen;
    logic        ill;
    logic        mv;
    logic [3:0]  mop;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic [31:0] inst, input logic [63:0] pc,
                     input logic [63:0] s1, input logic [63:0] s2, input logic chk_res,
                     input logic [63:0] res, input logic [63:0] npc, input logic wen,
                     input logic ill, input logic mv, input logic [3:0] mop);
    vec_t v;
    v.name = name; v.inst = inst; v.pc = pc; v.s1 = s1; v.s2 = s2;
    v.chk_res = chk_res; v.res = res; v.npc = npc; v.wen = wen;
    v.ill = ill; v.mv = mv; v.mop = mop;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    rst_i = 1'b1; pc_i = 64'h8000_0000; imem_rdata_i = 32'h0010_0073;
    src1_i = 64'h1234; src2_i = 64'h0;

    // Reset: EBREAK on the bus is replaced by NOP, halt stays clear.
    @(posedge clk_i); @(posedge clk_i); #1;
    chk("rst_halt",  {63'b0, halt_o}, 64'd0);
    chk("rst_inst",  {32'b0, inst_o}, 64'h13);
    chk("rst_res",   res_o, 64'h1234);
    chk("rst_npc",   npc_o, 64'h8000_0004);
    chk("rst_ill",   {63'b0, illegal_o}, 64'd0);
    chk("rst_mv",    {63'b0, mem_valid_o}, 64'd0);
    chk("rst_rd",    {59'b0, rd_o}, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0; imem_rdata_i = 32'h0000_0013;

    //   name        inst          pc                     s1                     s2                   cr res                    npc                    w  i  m  mop
    add("addi",     32'h00500093, 64'h8000_0000,         64'h0,                 64'h0,               1, 64'h5,                 64'h8000_0004,         1, 0, 0, 4'h0);
    add("sub",      32'h40208133, 64'h8000_0000,         64'h3,                 64'h5,               1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_0004,       1, 0, 0, 4'h0);
    add("sub_x0",   32'h40208033, 64'h8000_0000,         64'h3,                 64'h5,               1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_0004,       0, 0, 0, 4'h0);
    add("addiw",    32'h0010809B, 64'h8000_0000,         64'h7FFF_FFFF,         64'h0,               1, 64'hFFFF_FFFF_8000_0000, 64'h8000_0004,       1, 0, 0, 4'h0);
    add("beq_t",    32'h00208463, 64'h8000_0010,         64'h7,                 64'h7,               0, 64'h0,                 64'h8000_0018,         0, 0, 0, 4'h0);
    add("beq_nt",   32'h00208463, 64'h8000_0010,         64'h7,                 64'h8,               0, 64'h0,                 64'h8000_0014,         0, 0, 0, 4'h0);
    add("jalr",     32'h000080E7, 64'h8000_0020,         64'h8000_0101,         64'h0,               1, 64'h8000_0024,         64'h8000_0100,         1, 0, 0, 4'h0);
    add("unknown",  32'h0000007F, 64'h8000_0000,         64'h5,                 64'h5,               1, 64'h0,                 64'h8000_0004,         0, 1, 0, 4'h0);
    add("lui",      32'h123452B7, 64'h8000_0000,         64'h0,                 64'h0,               1, 64'h1234_5000,         64'h8000_0004,         1, 0, 0, 4'h0);
    add("lui_neg",  32'h800002B7, 64'h8000_0000,         64'h0,                 64'h0,               1, 64'hFFFF_FFFF_8000_0000, 64'h8000_0004,       1, 0, 0, 4'h0);
    add("auipc",    32'h00001097, 64'h8000_0000,         64'h0,                 64'h0,               1, 64'h8000_1000,         64'h8000_0004,         1, 0, 0, 4'h0);
    add("jal",      32'h010000EF, 64'h8000_0000,         64'h0,                 64'h0,               1, 64'h8000_0004,         64'h8000_0010,         1, 0, 0, 4'h0);
    add("jal_back", 32'hFFDFF06F, 64'h8000_0010,         64'h0,                 64'h0,               1, 64'h8000_0014,         64'h8000_000C,         0, 0, 0, 4'h0);
    add("srai",     32'h4040D093, 64'h8000_0000,         64'h8000_0000_0000_0000, 64'h0,             1, 64'hF800_0000_0000_0000, 64'h8000_0004,       1, 0, 0, 4'h0);
    add("srli",     32'h0040D093, 64'h8000_0000,         64'h8000_0000_0000_0000, 64'h0,             1, 64'h0800_0000_0000_0000, 64'h8000_0004,       1, 0, 0, 4'h0);
    add("slli_bad", 32'h40409093, 64'h8000_0000,         64'h1,                 64'h0,               1, 64'h0,                 64'h8000_0004,         0, 1, 0, 4'h0);
    add("slt",      32'h002021B3, 64'h8000_0000,         64'hFFFF_FFFF_FFFF_FFFF, 64'h1,             1, 64'h1,                 64'h8000_0004,         1, 0, 0, 4'h0);
    add("sltu",     32'h002031B3, 64'h8000_0000,         64'hFFFF_FFFF_FFFF_FFFF, 64'h1,             1, 64'h0,                 64'h8000_0004,         1, 0, 0, 4'h0);
    add("sraw",     32'h4020D0BB, 64'h8000_0000,         64'h0000_0000_8000_0000, 64'h24,            1, 64'hFFFF_FFFF_F800_0000, 64'h8000_0004,       1, 0, 0, 4'h0);
    add("srlw",     32'h0020D0BB, 64'h8000_0000,         64'h0000_0000_8000_0000, 64'h24,            1, 64'h0800_0000,         64'h8000_0004,         1, 0, 0, 4'h0);
    add("slliw_32", 32'h0200909B, 64'h8000_0000,         64'h1,                 64'h0,               1, 64'h0,                 64'h8000_0004,         0, 1, 0, 4'h0);
    add("ld",       32'h00813083, 64'h8000_0000,         64'h1000,              64'h0,               1, 64'h1008,              64'h8000_0004,         1, 0, 1, 4'b0011);
    add("sd",       32'hFE20BC23, 64'h8000_0000,         64'h1000,              64'h0,               1, 64'h0FF8,              64'h8000_0004,         0, 0, 1, 4'b1011);
    add("load_f7",  32'h00817083, 64'h8000_0000,         64'h1000,              64'h0,               1, 64'h0,                 64'h8000_0004,         0, 1, 0, 4'h0);
    add("ecall",    32'h00000073, 64'h8000_0040,         64'h0,                 64'h0,               0, 64'h0,                 64'h8000_0044,         0, 0, 0, 4'h0);
    add("blt_t",    32'h0020C463, 64'h8000_0010,         64'hFFFF_FFFF_FFFF_FFFF, 64'h1,             0, 64'h0,                 64'h8000_0018,         0, 0, 0, 4'h0);
    add("bltu_nt",  32'h0020E463, 64'h8000_0010,         64'hFFFF_FFFF_FFFF_FFFF, 64'h1,             0, 64'h0,                 64'h8000_0014,         0, 0, 0, 4'h0);
    add("br_bad",   32'h0020A463, 64'h8000_0010,         64'h1,                 64'h1,               1, 64'h0,                 64'h8000_0014,         0, 1, 0, 4'h0);

    foreach (vecs[i]) begin
      imem_rdata_i = vecs[i].inst; pc_i = vecs[i].pc;
      src1_i = vecs[i].s1; src2_i = vecs[i].s2;
      #1;
      if (vecs[i].chk_res) chk({vecs[i].name, ".res"}, res_o, vecs[i].res);
      chk({vecs[i].name, ".npc"}, npc_o, vecs[i].npc);
      chk({vecs[i].name, ".wen"}, {63'b0, wen_o}, {63'b0, vecs[i].wen});
      chk({vecs[i].name, ".ill"}, {63'b0, illegal_o}, {63'b0, vecs[i].ill});
      chk({vecs[i].name, ".mv"},  {63'b0, mem_valid_o}, {63'b0, vecs[i].mv});
      if (vecs[i].mv) chk({vecs[i].name, ".mop"}, {60'b0, mem_op_o}, {60'b0, vecs[i].mop});
      #1;
    end

    // Field extraction and fetch address on the SUB encoding.
    imem_rdata_i = 32'h40208133; pc_i = 64'h8000_0abc; #1;
    chk("imem_addr", imem_addr_o, 64'h8000_0abc);
    chk("rs1", {59'b0, rs1_o}, 64'd1);
    chk("rs2", {59'b0, rs2_o}, 64'd2);
    chk("rd",  {59'b0, rd_o},  64'd2);
    chk("inst", {32'b0, inst_o}, 64'h4020_8133);

    // Halt: before EBREAK, set by one EBREAK edge, sticky through NOPs.
    @(negedge clk_i); imem_rdata_i = 32'h0000_0013;
    @(posedge clk_i); #1;
    chk("halt_pre", {63'b0, halt_o}, 64'd0);
    @(negedge clk_i); imem_rdata_i = 32'h0010_0073;
    #1;
    chk("ebreak_wen", {63'b0, wen_o}, 64'd0);
    chk("ebreak_ill", {63'b0, illegal_o}, 64'd0);
    @(posedge clk_i); #1;
    chk("halt_set", {63'b0, halt_o}, 64'd1);
    @(negedge clk_i); imem_rdata_i = 32'h0000_0013;
    @(posedge clk_i); @(posedge clk_i); #1;
    chk("halt_sticky", {63'b0, halt_o}, 64'd1);

    // One reset edge clears it.
    @(negedge clk_i); rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("halt_clr", {63'b0, halt_o}, 64'd0);

    // Reset wins over a simultaneous EBREAK.
    @(negedge clk_i); imem_rdata_i = 32'h0010_0073;
    @(posedge clk_i); #1;
    chk("halt_rst_prio", {63'b0, halt_o}, 64'd0);
    @(negedge clk_i); rst_i = 1'b0; imem_rdata_i = 32'h0000_0013;
    @(posedge clk_i); #1;
    chk("halt_after_rst", {63'b0, halt_o}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
